// File: rtl/mgt_01_pkg.sv
// Shared types and constants for the mgt_01 interrupt-context slice.
package mgt_01_pkg;

  localparam int unsigned CTX_NREG      = 32;
  localparam logic [31:0] CTX_BASE_ADDR = 32'h0000_0100;

  typedef logic [31:0] data_bus_t;

  typedef enum logic [2:0] {
    CTX_IDLE    = 3'd0,
    CTX_SAVE    = 3'd1,
    CTX_RD_REQ  = 3'd2,
    CTX_RD_WAIT = 3'd3,
    CTX_LOAD    = 3'd4,
    CTX_FINISH  = 3'd5
  } ctx_state_e;

endpackage

// File: rtl/mgt_01_irq_ctx_unit.sv
// Interrupt context engine: streams x1..x(NREG-1) to memory on save, and reads
// them back into a buffer that is loaded into the register file in one cycle on restore.
module mgt_01_irq_ctx_unit
  import mgt_01_pkg::*;
#(
  parameter int unsigned NREG      = CTX_NREG,
  parameter int unsigned DW        = $bits(data_bus_t),
  parameter logic [31:0] BASE_ADDR = CTX_BASE_ADDR
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clk_en_i,
  input  logic               save_req_i,
  input  logic               restore_req_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic [NREG*DW-1:0] rf_snap_i,
  output logic               rf_load_o,
  output logic [NREG*DW-1:0] rf_data_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [DW-1:0]      mem_wdata_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [DW-1:0]      mem_rdata_i
);

  localparam int unsigned   IW   = $clog2(NREG);
  localparam logic [IW-1:0] LAST = IW'(NREG - 1);

  ctx_state_e    r_state, w_state_d;
  logic [IW-1:0] r_idx, w_idx_d, w_idx_m1;
  logic [DW-1:0] r_snap [NREG];
  logic [DW-1:0] r_buf  [NREG-1:1];
  logic [31:0]   w_addr;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    unique case (r_state)
      CTX_IDLE: begin
        // save has priority; a simultaneous restore request is dropped
        if (save_req_i) begin
          w_state_d = CTX_SAVE;
          w_idx_d   = IW'(1);
        end else if (restore_req_i) begin
          w_state_d = CTX_RD_REQ;
          w_idx_d   = IW'(1);
        end
      end
      CTX_SAVE: begin
        if (mem_gnt_i) begin
          if (r_idx == LAST) w_state_d = CTX_FINISH;
          else               w_idx_d   = r_idx + IW'(1);
        end
      end
      CTX_RD_REQ: begin
        if (mem_gnt_i) w_state_d = CTX_RD_WAIT;
      end
      CTX_RD_WAIT: begin
        if (mem_rvalid_i) begin
          if (r_idx == LAST) begin
            w_state_d = CTX_LOAD;
          end else begin
            w_state_d = CTX_RD_REQ;
            w_idx_d   = r_idx + IW'(1);
          end
        end
      end
      CTX_LOAD:   w_state_d = CTX_FINISH;
      CTX_FINISH: w_state_d = CTX_IDLE;
      default:    w_state_d = CTX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= CTX_IDLE;
      r_idx   <= IW'(1);
    end else if (clk_en_i) begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(NREG); i++) r_snap[i] <= '0;
      for (int i = 1; i < int'(NREG); i++) r_buf[i] <= '0;
    end else if (clk_en_i) begin
      if (r_state == CTX_IDLE && save_req_i) begin
        for (int i = 0; i < int'(NREG); i++) r_snap[i] <= rf_snap_i[i*DW +: DW];
      end
      if (r_state == CTX_RD_WAIT && mem_rvalid_i) begin
        r_buf[r_idx] <= mem_rdata_i;
      end
    end
  end

  assign w_idx_m1 = r_idx - IW'(1);
  assign w_addr   = BASE_ADDR + 32'({w_idx_m1, 2'b00});

  // Memory outputs depend only on state/idx/snapshot, so they hold while gnt is low
  assign busy_o      = (r_state != CTX_IDLE);
  assign done_o      = (r_state == CTX_FINISH);
  assign rf_load_o   = (r_state == CTX_LOAD);
  assign mem_req_o   = (r_state == CTX_SAVE) || (r_state == CTX_RD_REQ);
  assign mem_we_o    = (r_state == CTX_SAVE);
  assign mem_addr_o  = mem_req_o ? w_addr : '0;
  assign mem_wdata_o = mem_we_o ? r_snap[r_idx] : '0;

  always_comb begin
    rf_data_o = '0;
    for (int i = 1; i < int'(NREG); i++) rf_data_o[i*DW +: DW] = r_buf[i];
  end

endmodule

// File: tb/tb_mgt_01_irq_ctx_unit.sv
// Directed bench for mgt_01_irq_ctx_unit with a cycle-by-cycle memory responder.
module tb_mgt_01_irq_ctx_unit;

  localparam int NREG = 32;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clk_en;
  logic               save_req;
  logic               restore_req;
  logic               busy;
  logic               done;
  logic [NREG*DW-1:0] rf_snap;
  logic               rf_load;
  logic [NREG*DW-1:0] rf_data;
  logic               mem_req;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [DW-1:0]      mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mgt_01_irq_ctx_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clk_en_i      (clk_en),
    .save_req_i    (save_req),
    .restore_req_i (restore_req),
    .busy_o        (busy),
    .done_o        (done),
    .rf_snap_i     (rf_snap),
    .rf_load_o     (rf_load),
    .rf_data_o     (rf_data),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_snap;
    for (int i = 0; i < NREG; i++) rf_snap[i*DW +: DW] = 32'hA000_0000 + i;
  endtask

  // Issues a request at cycle 0 and then plays memory until done_o (or a planned reset).
  task automatic run_op(input bit do_save, input bit do_restore, input int hold_w,
                        input int hold_n, input int en_at, input int en_n, input int rst_w,
                        input int late_restore, output int done_cyc, output int load_cyc,
                        output int nst, output int nld, output int npulse);
    int cyc;
    int ex_w;
    int hold_cnt;
    int pend_i;
    bit pend;
    bit fin;
    done_cyc = -1; load_cyc = -1; nst = 0; nld = 0; npulse = 0;
    ex_w = 1; hold_cnt = 0; pend = 0; pend_i = 0; fin = 0;
    save_req = do_save; restore_req = do_restore;
    tick;
    save_req = 0; restore_req = 0;
    cyc = 1;
    while (!fin && cyc < 300) begin
      if (cyc == 1) rf_snap = ~rf_snap;
      clk_en      = !(cyc >= en_at && cyc < en_at + en_n);
      restore_req = (cyc == late_restore);
      mem_rvalid  = pend;
      mem_rdata   = 32'h5A00_0000 + pend_i;
      mem_gnt     = 1'b1;
      check("busy", busy, 1);
      if (pend && clk_en) pend = 0;
      if (mem_req) begin
        if (rst_w > 0 && ex_w == rst_w) begin
          rst_n = 0;
          #1;
          check("rst_req", mem_req, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          fin = 1;
        end else begin
          check("addr", mem_addr, 32'h100 + 4 * (ex_w - 1));
          check("we", mem_we, do_save);
          if (mem_we) check("wdata", mem_wdata, 32'hA000_0000 + ex_w);
          if (ex_w == hold_w && hold_cnt < hold_n) begin
            mem_gnt = 0;
            hold_cnt++;
          end
          if (mem_gnt && clk_en) begin
            if (mem_we) nst++;
            else begin
              nld++;
              pend   = 1;
              pend_i = ex_w;
            end
            ex_w++;
          end
        end
      end
      if (!fin && rf_load) begin
        load_cyc = cyc;
        npulse++;
        for (int i = 0; i < NREG; i++)
          check("rf_data", rf_data[i*DW +: DW], (i == 0) ? 32'h0 : 32'h5A00_0000 + i);
      end
      if (!fin && done) begin
        done_cyc = cyc;
        fin = 1;
      end
      if (!fin) begin
        tick;
        cyc++;
      end
    end
    if (!fin) check("timeout", 0, 1);
    clk_en = 1; restore_req = 0; mem_rvalid = 0; mem_gnt = 0;
  endtask

  int d, l, ns, nl, np;

  initial begin
    rst_n = 0; clk_en = 1; save_req = 0; restore_req = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; rf_snap = '0;
    repeat (2) tick;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_req", mem_req, 0);
    check("reset_addr", mem_addr, 0);
    check("reset_load", rf_load, 0);
    check("reset_rfdata", {32'h0, rf_data[63:32]}, 0);
    rst_n = 1;
    tick;

    // Plain save
    set_snap;
    run_op(1, 0, -1, 0, 1000, 0, 0, -1, d, l, ns, nl, np);
    check("t1_done_cyc", d, 32);
    check("t1_stores", ns, 31);
    check("t1_loads", nl, 0);
    tick;
    check("t1_idle", busy, 0);
    check("t1_done_low", done, 0);

    // Plain restore
    run_op(0, 1, -1, 0, 1000, 0, 0, -1, d, l, ns, nl, np);
    check("t2_load_cyc", l, 63);
    check("t2_done_cyc", d, 64);
    check("t2_loads", nl, 31);
    check("t2_pulses", np, 1);
    tick;
    check("t2_idle", busy, 0);

    // gnt withheld for 3 cycles on word 7
    set_snap;
    run_op(1, 0, 7, 3, 1000, 0, 0, -1, d, l, ns, nl, np);
    check("t3_done_cyc", d, 35);
    check("t3_stores", ns, 31);
    tick;

    // Simultaneous requests, plus a restore request mid-save
    set_snap;
    run_op(1, 1, -1, 0, 1000, 0, 0, 5, d, l, ns, nl, np);
    check("t4_done_cyc", d, 32);
    check("t4_stores", ns, 31);
    check("t4_loads", nl, 0);
    tick;
    check("t4_idle", busy, 0);
    tick;
    check("t4_no_restart", mem_req, 0);

    // clk_en low for 5 cycles during restore
    run_op(0, 1, -1, 0, 20, 5, 0, -1, d, l, ns, nl, np);
    check("t5_load_cyc", l, 68);
    check("t5_done_cyc", d, 69);
    check("t5_loads", nl, 31);
    check("t5_pulses", np, 1);
    tick;

    // Reset at word 10 of a save
    set_snap;
    run_op(1, 0, -1, 0, 1000, 0, 10, -1, d, l, ns, nl, np);
    check("t6_stores", ns, 9);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t6_done_held", done, 0);
      check("t6_req_held", mem_req, 0);
    end
    check("t6_buf_clear", {32'h0, rf_data[10*DW +: DW]}, 0);
    rst_n = 1;
    tick;
    check("t6_idle", busy, 0);
    set_snap;
    run_op(1, 0, -1, 0, 1000, 0, 0, -1, d, l, ns, nl, np);
    check("t6_redo_done", d, 32);
    check("t6_redo_stores", ns, 31);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
